// File: rtl/ser_demux.sv
// ser_demux: framed serial demultiplexer steering payload bits to
// one of 2**PORT_W channels with one-hot valid strobes.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   clkEn  - sample enable; FSM and counters advance only when high
//   serIn  - serial line, idle high
//   dOut   - registered payload bit
//   valid  - one-hot strobe qualifying dOut for channel `port`
//   port   - latched channel address of the current/last frame
//   busy   - FSM not in IDLE (decoded from state)
//   done   - one-cycle pulse at frame completion
//   err    - one-cycle pulse on a stop-bit violation
module ser_demux #(
    parameter int PORT_W   = 2,
    parameter int LEN_W    = 4,
    parameter int STOP_CHK = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clkEn,
    input  logic                 serIn,
    output logic                 dOut,
    output logic [2**PORT_W-1:0] valid,
    output logic [PORT_W-1:0]    port,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int NCH   = 2**PORT_W;
    localparam int CNT_W = (PORT_W > LEN_W) ? PORT_W : LEN_W;

    localparam logic [CNT_W-1:0] PORT_LD = CNT_W'(PORT_W - 1);
    localparam logic [CNT_W-1:0] LEN_LD  = CNT_W'(LEN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        PORT,
        LEN,
        DATA,
        STOP
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [LEN_W-1:0]   len_q, len_n, len_nx;
    logic [PORT_W-1:0]  port_n;
    logic               dout_n;
    logic [NCH-1:0]     valid_n;
    logic               done_n;
    logic               err_n;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            len_q <= '0;
            port  <= '0;
            dOut  <= 1'b0;
            valid <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            len_q <= len_n;
            port  <= port_n;
            dOut  <= dout_n;
            valid <= valid_n;
            done  <= done_n;
            err   <= err_n;
        end
    end

    // Strobes default low so they never stretch over disabled cycles.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len_q;
        port_n  = port;
        dout_n  = dOut;
        valid_n = '0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        len_nx  = LEN_W'({len_q, serIn});
        if (clkEn) begin
            unique case (state)
                IDLE: begin
                    if (!serIn) begin
                        state_n = PORT;
                        cnt_n   = PORT_LD;
                    end
                end
                PORT: begin
                    port_n = PORT_W'({port, serIn});
                    if (cnt == '0) begin
                        state_n = LEN;
                        cnt_n   = LEN_LD;
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
                LEN: begin
                    len_n = len_nx;
                    if (cnt == '0) begin
                        if (len_nx != '0) begin
                            state_n = DATA;
                            // counter holds remaining bits minus one
                            cnt_n   = CNT_W'(len_nx - LEN_W'(1));
                        end else if (STOP_CHK != 0) begin
                            state_n = STOP;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
                DATA: begin
                    dout_n  = serIn;
                    valid_n = NCH'(1) << port;
                    if (cnt == '0) begin
                        if (STOP_CHK != 0) begin
                            state_n = STOP;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
                STOP: begin
                    // a low stop bit is an error, never a new start
                    state_n = IDLE;
                    if (serIn) done_n = 1'b1;
                    else       err_n  = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ser_demux.sv
// tb_ser_demux: directed-vector bench for ser_demux.
// Two instances: stop-bit checking on (dut) and off (dut0).
module tb_ser_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic       clkEn;
    logic       ser;
    logic       ser0;

    logic       dOut, busy, done, err;
    logic [3:0] valid;
    logic [1:0] port;
    logic       dOut0, busy0, done0, err0;
    logic [3:0] valid0;
    logic [1:0] port0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int         nv, nd, ne, stray, nbusy, eedge;
    int         vedge [8];
    int         vcyc  [8];
    logic [3:0] vval  [8];
    logic       dbit  [8];
    int         dedge [4];

    ser_demux #(.PORT_W(2), .LEN_W(4), .STOP_CHK(1)) dut (
        .clk(clk), .rst(rst), .clkEn(clkEn), .serIn(ser),
        .dOut(dOut), .valid(valid), .port(port),
        .busy(busy), .done(done), .err(err)
    );

    ser_demux #(.PORT_W(2), .LEN_W(4), .STOP_CHK(0)) dut0 (
        .clk(clk), .rst(rst), .clkEn(clkEn), .serIn(ser0),
        .dOut(dOut0), .valid(valid0), .port(port0),
        .busy(busy0), .done(done0), .err(err0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic observe(input bit which, input int i);
        logic [3:0] v;
        logic       d, dn, er, b;
        v  = which ? valid0 : valid;
        d  = which ? dOut0  : dOut;
        dn = which ? done0  : done;
        er = which ? err0   : err;
        b  = which ? busy0  : busy;
        if (v != 4'b0) begin
            if (nv < 8) begin
                vedge[nv] = i;
                vcyc[nv]  = cyc;
                vval[nv]  = v;
                dbit[nv]  = d;
            end
            nv++;
        end
        if (dn) begin
            if (nd < 4) dedge[nd] = i;
            nd++;
        end
        if (er) begin
            eedge = i;
            ne++;
        end
        if (b) nbusy++;
    endtask

    function automatic bit any_evt(input bit which);
        if (which) return (valid0 != 4'b0) || done0 || err0;
        return (valid != 4'b0) || done || err;
    endfunction

    // Sends n bits MSB first, one per enabled edge, with
    // gap-1 disabled cycles after each enabled edge.
    task automatic frame(input bit which, input logic [63:0] bits,
                         input int n, input int gap);
        nv = 0; nd = 0; ne = 0; stray = 0; nbusy = 0; eedge = -1;
        for (int i = 0; i < n; i++) begin
            if (which) ser0 = bits[n-1-i];
            else       ser  = bits[n-1-i];
            clkEn = 1'b1;
            tick();
            observe(which, i);
            for (int g = 1; g < gap; g++) begin
                clkEn = 1'b0;
                tick();
                if (any_evt(which)) stray++;
            end
        end
        clkEn = 1'b1;
        ser   = 1'b1;
        ser0  = 1'b1;
    endtask

    task automatic check_frame1(input string p);
        check({p, "_nv"},   nv, 3);
        check({p, "_v0"},   vval[0], 4'b0100);
        check({p, "_v1"},   vval[1], 4'b0100);
        check({p, "_v2"},   vval[2], 4'b0100);
        check({p, "_d0"},   dbit[0], 1'b1);
        check({p, "_d1"},   dbit[1], 1'b0);
        check({p, "_d2"},   dbit[2], 1'b1);
        check({p, "_e0"},   vedge[0], 7);
        check({p, "_e2"},   vedge[2], 9);
        check({p, "_nd"},   nd, 1);
        check({p, "_dedg"}, dedge[0], 10);
        check({p, "_ne"},   ne, 0);
        check({p, "_port"}, port, 2'd2);
        check({p, "_hold"}, dOut, 1'b1);
        check({p, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        clkEn = 1'b0;
        ser   = 1'b1;
        ser0  = 1'b1;
        #2 rst = 1'b0;
        tick();
        tick();
        check("rst_valid", valid, 4'b0);
        check("rst_dout",  dOut,  1'b0);
        check("rst_port",  port,  2'd0);
        check("rst_busy",  busy,  1'b0);
        check("rst_done",  done,  1'b0);
        check("rst_err",   err,   1'b0);
        rst = 1'b1;
        clkEn = 1'b1;
        tick();

        // 0 | 10 | 0011 | 101 | 1
        frame(0, 64'b0_10_0011_101_1, 11, 1);
        check_frame1("f1");

        // zero-length: 0 | 01 | 0000 | 1
        frame(0, 64'b0_01_0000_1, 8, 1);
        check("zl_nv",   nv, 0);
        check("zl_nd",   nd, 1);
        check("zl_dedg", dedge[0], 7);
        check("zl_nbsy", nbusy, 7);
        check("zl_busy", busy, 1'b0);
        check("zl_port", port, 2'd1);

        // bad stop: 0 | 11 | 0001 | 1 | 0
        frame(0, 64'b0_11_0001_1_0, 9, 1);
        check("bs_nv",   nv, 1);
        check("bs_v0",   vval[0], 4'b1000);
        check("bs_d0",   dbit[0], 1'b1);
        check("bs_ne",   ne, 1);
        check("bs_eedg", eedge, 8);
        check("bs_nd",   nd, 0);
        tick();
        check("bs_busy", busy, 1'b0);
        check("bs_err2", err, 1'b0);

        // clkEn one cycle in three
        frame(0, 64'b0_10_0011_101_1, 11, 3);
        check_frame1("ce");
        check("ce_sp1",   vcyc[1] - vcyc[0], 3);
        check("ce_sp2",   vcyc[2] - vcyc[1], 3);
        check("ce_stray", stray, 0);

        // reset after first payload bit
        frame(0, 64'b0_10_0011_1, 8, 1);
        check("mr_pre_v", valid, 4'b0100);
        check("mr_pre_b", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("mr_valid", valid, 4'b0);
        check("mr_dout",  dOut,  1'b0);
        check("mr_port",  port,  2'd0);
        check("mr_busy",  busy,  1'b0);
        check("mr_done",  done,  1'b0);
        check("mr_err",   err,   1'b0);
        tick();
        rst = 1'b1;
        frame(0, 64'b1_1111_1111, 9, 1);
        check("mr_idle_v", nv, 0);
        check("mr_idle_d", nd, 0);
        check("mr_idle_e", ne, 0);
        frame(0, 64'b0_10_0011_101_1, 11, 1);
        check_frame1("mr");

        // STOP_CHK=0 back to back: port0 L=2 "11"; port3 L=1 "0"
        frame(1, 64'b0_00_0010_11_0_11_0001_0, 17, 1);
        check("bb_nv",   nv, 3);
        check("bb_v0",   vval[0], 4'b0001);
        check("bb_v1",   vval[1], 4'b0001);
        check("bb_v2",   vval[2], 4'b1000);
        check("bb_d0",   dbit[0], 1'b1);
        check("bb_d1",   dbit[1], 1'b1);
        check("bb_d2",   dbit[2], 1'b0);
        check("bb_e2",   vedge[2], 16);
        check("bb_nd",   nd, 2);
        check("bb_dn0",  dedge[0], 8);
        check("bb_dn1",  dedge[1], 16);
        check("bb_ne",   ne, 0);
        check("bb_port", port0, 2'd3);
        check("bb_busy", busy0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
